fire7_squeeze_ofm_serializer: RTL and testbench
===============================================

Name: fire7_squeeze_ofm_serializer

Overview:
- Sits downstream of the fire7 squeeze layer.
- Captures each parallel DSP_NO-wide output-pixel vector (one word per output channel) when the layer's sampling strobe fires.
- Re-emits the vector as a serial one-word-per-cycle stream, channel 0 first, with a valid/ready handshake. This is the same serial format the squeeze layer consumes on its ifm input, so the expand stage can be fed.
- Double-buffered (ping-pong), so a new vector can be captured while the previous one is still streaming.

Parameters:
- DSP_NO, 64, channels per captured vector (output channels of the producing layer)
- WIDTH, 16, bits per feature-map word
- W_IN, 16, feature-map width in pixels
- H_IN, 16, feature-map height in pixels
- NPIX, W_IN*H_IN, vectors per layer (derived)

Ports:
- clk  in  1  clock, all logic on posedge clk
- rst  in  1  reset, synchronous, active-low
- ofm_valid  in  1  one-cycle strobe: ofm_in holds a complete pixel vector
- ofm_in  in  WIDTH x [0:DSP_NO-1]  parallel channel words from the producing layer
- ifm_ready  in  1  downstream accepts ifm_out this cycle
- ifm_out  out  WIDTH  serial channel word
- ifm_valid  out  1  ifm_out is valid
- ch_idx  out  $clog2(DSP_NO)  channel index of ifm_out
- pix_idx  out  $clog2(NPIX)  pixel index of ifm_out
- last_ch  out  1  ifm_out is channel DSP_NO-1
- overflow  out  1  sticky: a vector was dropped because both banks were full
- done  out  1  sticky: all NPIX vectors have been streamed

Behaviour:
Reset and transfer rules
- Reset: rst=0 sampled at a clk edge clears everything. ifm_valid, ifm_out, ch_idx, pix_idx, last_ch, overflow and done all go to 0; both banks go empty; wr_sel=0, rd_sel=0.
- Reset mid-operation discards buffered data. There is no partial flush.
- Transfer occurs when ifm_valid & ifm_ready.
- ifm_out, ch_idx, pix_idx and last_ch stay stable while ifm_valid=1 and ifm_ready=0.

Capture
- On ofm_valid with bank[wr_sel] empty, and done=0 and total_captured<NPIX: copy all DSP_NO words into bank[wr_sel], mark it full, toggle wr_sel.
- If bank[wr_sel] is full: drop the vector and set overflow (sticky until reset).
- ofm_valid arriving when done=1 or after NPIX captures: ignored, no overflow.
- Same-cycle free: if the last word of bank[wr_sel] transfers in the same cycle as ofm_valid, that bank counts as free and the capture succeeds.

Read FSM (IDLE, STREAM, DONE)
- IDLE: ifm_valid=0. When bank[rd_sel] is full, go to STREAM with ch_idx=0.
  - Latency: ofm_valid at edge t into an empty, idle serializer gives ifm_valid=1 with channel 0 at edge t+1.
- STREAM: ifm_valid=1 and ifm_out=bank[rd_sel][ch_idx].
  - On transfer with ch_idx<DSP_NO-1: ch_idx++.
  - On transfer with ch_idx=DSP_NO-1: mark bank empty, toggle rd_sel, ch_idx=0, pix_idx++.
    - If pix_idx was NPIX-1: go to DONE.
    - Else if the other bank is full: stay in STREAM with no bubble.
    - Else: go to IDLE.
- DONE: ifm_valid=0, done=1, until reset.

Arithmetic and widths
- Data passes through unmodified; no rounding, saturation or bias.
- pix_idx saturates in DONE and does not wrap.
- last_ch = (ch_idx==DSP_NO-1) & ifm_valid.

Decomposition:
- Shared package fire_pkg holds:
  - constants WIDTH, DSP_NO
  - typedef fm_word_t (logic [WIDTH-1:0])
  - typedef fm_vec_t (fm_word_t [0:DSP_NO-1])
  - enum ser_state_t {IDLE, STREAM, DONE}
- One natural sub-module: fm_pingpong_buf, holding two banks, full flags, and the wr_sel/rd_sel pointers, with capture and release ports.
- The FSM and counters stay in the top module.

Test Plan:
- Single vector, ready tied 1: ofm_in[i]=i+100, strobe at cycle 0 -> ifm_valid from cycle 1; ifm_out=100..163 on cycles 1..64; last_ch=1 at cycle 64; pix_idx=0; ifm_valid=0 at cycle 65.
- Back-to-back, ready=1: strobes at cycles 0 and 10 (vectors A, B) -> 128 consecutive valid words, A then B with no bubble; pix_idx steps 0->1 at word 64; overflow=0.
- Overflow: ready=0, strobes at cycles 0, 5, 9 -> the third vector is dropped and overflow=1 from cycle 10. With ready then raised, only vectors 1 and 2 are emitted.
- Backpressure: ready toggled 1,0,0,1,… during a stream -> ifm_out/ch_idx hold while ready=0; no word is skipped or duplicated, checked against a scoreboard over 64 words.
- Same-cycle free: both banks full, strobe coincides with the last-word transfer of the read bank -> capture accepted, overflow stays 0, the new vector is emitted after the pending one.
- Full layer plus reset: 256 strobes every 65 cycles, ready=1 -> done=1 after the 16384th transfer, and a 257th strobe is ignored with overflow=0. Asserting rst=0 mid-stream at word 30 -> all outputs are 0 at the next edge and the next strobe restarts at pix_idx=0.

Source files
------------

// File: rtl/fire_pkg.sv
// Shared word/vector types and sizing for the fire7 squeeze output path.
package fire_pkg;
  localparam int WIDTH  = 16;
  localparam int DSP_NO = 64;

  typedef logic [WIDTH-1:0] fm_word_t;
  typedef fm_word_t [0:DSP_NO-1] fm_vec_t;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} ser_state_t;
endpackage

// File: rtl/fm_pingpong_buf.sv
// Two-bank vector store: whole-vector capture on one side, word-wise read on the other.
module fm_pingpong_buf
  import fire_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        capture,
  input  logic [0:DSP_NO-1][WIDTH-1:0] cap_data,
  input  logic                        free,
  input  logic [$clog2(DSP_NO)-1:0]   rd_ch,
  output logic [WIDTH-1:0]            rd_word,
  output logic                        can_capture,
  output logic                        rd_full,
  output logic                        other_full
);
  fm_vec_t    bank [0:1];
  logic [1:0] full_reg;
  logic       wr_sel_reg;
  logic       rd_sel_reg;

  // Capture is applied after free so a bank released and refilled in one cycle ends up full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_reg   <= 2'b00;
      wr_sel_reg <= 1'b0;
      rd_sel_reg <= 1'b0;
    end else begin
      if (free) begin
        full_reg[rd_sel_reg] <= 1'b0;
        rd_sel_reg           <= ~rd_sel_reg;
      end
      if (capture) begin
        full_reg[wr_sel_reg] <= 1'b1;
        wr_sel_reg           <= ~wr_sel_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) bank[wr_sel_reg] <= cap_data;
  end

  assign rd_word     = bank[rd_sel_reg][rd_ch];
  assign can_capture = !full_reg[wr_sel_reg] || (free && (wr_sel_reg == rd_sel_reg));
  assign rd_full     = full_reg[rd_sel_reg];
  assign other_full  = full_reg[~rd_sel_reg];
endmodule

// File: rtl/fire7_squeeze_ofm_serializer.sv
// Captures parallel squeeze-layer pixel vectors and replays them one channel word per cycle.
module fire7_squeeze_ofm_serializer
  import fire_pkg::*;
#(
  parameter int W_IN = 16,
  parameter int H_IN = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ofm_valid,
  input  logic [0:DSP_NO-1][WIDTH-1:0]  ofm_in,
  input  logic                          ifm_ready,
  output logic [WIDTH-1:0]              ifm_out,
  output logic                          ifm_valid,
  output logic [$clog2(DSP_NO)-1:0]     ch_idx,
  output logic [$clog2(W_IN*H_IN)-1:0]  pix_idx,
  output logic                          last_ch,
  output logic                          overflow,
  output logic                          done
);
  localparam int NPIX = W_IN * H_IN;
  localparam int CW   = $clog2(DSP_NO);
  localparam int PW   = $clog2(NPIX);
  localparam logic [CW-1:0] LAST_CH  = CW'(DSP_NO - 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

  ser_state_t       state_reg, state_next;
  logic [CW-1:0]    ch_reg;
  logic [PW-1:0]    pix_reg;
  logic [PW:0]      cap_cnt_reg;
  logic             overflow_reg;
  logic             xfer, last_xfer, in_window, capture;
  logic             can_capture, rd_full, other_full;
  logic [WIDTH-1:0] rd_word;

  assign xfer      = (state_reg == STREAM) && ifm_ready;
  assign last_xfer = xfer && (ch_reg == LAST_CH);
  // Strobes after the layer is complete are silently ignored rather than counted as overflow.
  assign in_window = ofm_valid && (state_reg != DONE) && (cap_cnt_reg < (PW+1)'(NPIX));
  assign capture   = in_window && can_capture;

  fm_pingpong_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .capture     (capture),
    .cap_data    (ofm_in),
    .free        (last_xfer),
    .rd_ch       (ch_reg),
    .rd_word     (rd_word),
    .can_capture (can_capture),
    .rd_full     (rd_full),
    .other_full  (other_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (rd_full) state_next = STREAM;
      STREAM: if (last_xfer) begin
                if (pix_reg == LAST_PIX) state_next = DONE;
                else if (!other_full)    state_next = IDLE;
              end
      DONE:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ifm_valid = (state_reg == STREAM);
    done      = (state_reg == DONE);
    ifm_out   = ifm_valid ? rd_word : '0;
    last_ch   = ifm_valid && (ch_reg == LAST_CH);
    ch_idx    = ch_reg;
    pix_idx   = pix_reg;
    overflow  = overflow_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_reg       <= '0;
      pix_reg      <= '0;
      cap_cnt_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (xfer) begin
        if (ch_reg == LAST_CH) begin
          ch_reg <= '0;
          if (pix_reg != LAST_PIX) pix_reg <= pix_reg + 1'b1;
        end else begin
          ch_reg <= ch_reg + 1'b1;
        end
      end
      if (capture) cap_cnt_reg <= cap_cnt_reg + 1'b1;
      if (in_window && !can_capture) overflow_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fire7_squeeze_ofm_serializer.sv
// Self-checking bench: cycle table for a single vector plus scoreboarded multi-vector scenarios.
`timescale 1ns/1ps
module tb_fire7_squeeze_ofm_serializer;
  import fire_pkg::*;

  logic clk = 1'b0;
  logic rst, ofm_valid, ifm_ready;
  logic [0:DSP_NO-1][WIDTH-1:0] ofm_in;
  logic [WIDTH-1:0] ifm_out;
  logic ifm_valid, last_ch, overflow, done;
  logic [5:0] ch_idx;
  logic [7:0] pix_idx;

  typedef struct { logic [WIDTH-1:0] data; int ch; int pix; } exp_t;
  typedef struct { int cyc; logic v; logic [WIDTH-1:0] out; int ch; int pix; logic last; } t1_vec_t;

  exp_t    sb[$];
  t1_vec_t t1 [7];
  int compared = 0, mismatched = 0;
  int cyc = 0, xfer_cnt = 0, first_xfer = 0, last_xfer_cyc = 0, exp_pix = 0;
  logic hold_valid = 1'b0;
  logic [WIDTH-1:0] hold_out;
  logic [5:0] hold_ch;
  logic [7:0] hold_pix;

  always #5 clk = ~clk;

  fire7_squeeze_ofm_serializer #(.W_IN(16), .H_IN(16)) dut (
    .clk(clk), .rst(rst), .ofm_valid(ofm_valid), .ofm_in(ofm_in), .ifm_ready(ifm_ready),
    .ifm_out(ifm_out), .ifm_valid(ifm_valid), .ch_idx(ch_idx), .pix_idx(pix_idx),
    .last_ch(last_ch), .overflow(overflow), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Evaluated just before each active edge, with the inputs that edge will sample.
  task automatic monitor();
    exp_t e;
    if (hold_valid) begin
      compared++;
      if (ifm_valid !== 1'b1 || ifm_out !== hold_out || ch_idx !== hold_ch || pix_idx !== hold_pix) begin
        mismatched++;
        $display("FAIL hold: got v=%b out=%h ch=%0d pix=%0d, required v=1 out=%h ch=%0d pix=%0d",
                 ifm_valid, ifm_out, ch_idx, pix_idx, hold_out, hold_ch, hold_pix);
      end
    end
    hold_valid = rst && ifm_valid && !ifm_ready;
    hold_out = ifm_out; hold_ch = ch_idx; hold_pix = pix_idx;
    if (rst && ifm_valid && ifm_ready) begin
      compared++;
      if (xfer_cnt == 0) first_xfer = cyc;
      last_xfer_cyc = cyc;
      xfer_cnt++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_word: got out=%h ch=%0d pix=%0d, required no transfer", ifm_out, ch_idx, pix_idx);
      end else begin
        e = sb.pop_front();
        if (ifm_out !== e.data || ch_idx !== 6'(e.ch) || pix_idx !== 8'(e.pix) || last_ch !== (e.ch == DSP_NO-1)) begin
          mismatched++;
          $display("FAIL stream_word: got out=%h ch=%0d pix=%0d last=%b, required out=%h ch=%0d pix=%0d last=%b",
                   ifm_out, ch_idx, pix_idx, last_ch, e.data, e.ch, e.pix, (e.ch == DSP_NO-1));
        end
      end
    end
  endtask

  task automatic tick();
    monitor();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [WIDTH-1:0] base, input bit accept);
    exp_t e;
    for (int i = 0; i < DSP_NO; i++) begin
      ofm_in[i] = base + WIDTH'(i);
      if (accept) begin
        e.data = base + WIDTH'(i); e.ch = i; e.pix = exp_pix;
        sb.push_back(e);
      end
    end
    if (accept) exp_pix++;
    ofm_valid = 1'b1;
    tick();
    ofm_valid = 1'b0;
  endtask

  task automatic drain(input int max, input bit bp);
    int k = 0;
    while (sb.size() != 0 && k < max) begin
      ifm_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      tick();
      k++;
    end
    ifm_ready = 1'b1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: got %0d words pending after %0d cycles, required 0", sb.size(), max);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; ofm_valid = 1'b0; hold_valid = 1'b0;
    tick();
    chk("rst_valid", ifm_valid, 0);
    chk("rst_out", ifm_out, 0);
    chk("rst_ch", ch_idx, 0);
    chk("rst_pix", pix_idx, 0);
    chk("rst_last", last_ch, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_done", done, 0);
    sb.delete();
    exp_pix = 0;
    rst = 1'b1;
  endtask

  initial begin
    t1[0] = '{0,  1'b0, 16'd0,   0,  0, 1'b0};
    t1[1] = '{1,  1'b1, 16'd100, 0,  0, 1'b0};
    t1[2] = '{2,  1'b1, 16'd101, 1,  0, 1'b0};
    t1[3] = '{33, 1'b1, 16'd132, 32, 0, 1'b0};
    t1[4] = '{63, 1'b1, 16'd162, 62, 0, 1'b0};
    t1[5] = '{64, 1'b1, 16'd163, 63, 0, 1'b1};
    t1[6] = '{65, 1'b0, 16'd0,   0,  1, 1'b0};

    rst = 1'b0; ofm_valid = 1'b0; ifm_ready = 1'b0; ofm_in = '0;
    do_reset();

    $display("phase single_vector");
    ifm_ready = 1'b1;
    pulse(16'd100, 1);
    for (int k = 0; k <= 65; k++) begin
      for (int j = 0; j < 7; j++) begin
        if (t1[j].cyc == k) begin
          chk($sformatf("t1_valid_c%0d", k), ifm_valid, t1[j].v);
          if (t1[j].v) chk($sformatf("t1_out_c%0d", k), ifm_out, t1[j].out);
          chk($sformatf("t1_ch_c%0d", k), ch_idx, t1[j].ch);
          chk($sformatf("t1_pix_c%0d", k), pix_idx, t1[j].pix);
          chk($sformatf("t1_last_c%0d", k), last_ch, t1[j].last);
        end
      end
      tick();
    end
    chk("t1_drained", sb.size(), 0);

    $display("phase back_to_back");
    do_reset();
    ifm_ready = 1'b1; xfer_cnt = 0;
    pulse(16'h1000, 1);
    idle(9);
    pulse(16'h2000, 1);
    drain(400, 0);
    chk("b2b_count", xfer_cnt, 128);
    chk("b2b_span", last_xfer_cyc - first_xfer, 127);
    chk("b2b_overflow", overflow, 0);

    $display("phase overflow");
    do_reset();
    ifm_ready = 1'b0;
    pulse(16'h3000, 1);
    idle(4);
    pulse(16'h4000, 1);
    idle(3);
    chk("ovf_before", overflow, 0);
    pulse(16'h5000, 0);
    chk("ovf_after", overflow, 1);
    drain(400, 0);
    idle(10);
    chk("ovf_idle", ifm_valid, 0);
    chk("ovf_sticky", overflow, 1);

    $display("phase backpressure");
    do_reset();
    ifm_ready = 1'b1;
    pulse(16'h6000, 1);
    drain(600, 1);
    idle(4);
    chk("bp_idle", ifm_valid, 0);

    $display("phase same_cycle_free");
    do_reset();
    ifm_ready = 1'b0;
    pulse(16'h7000, 1);
    pulse(16'h8000, 1);
    ifm_ready = 1'b1;
    for (int n = 0; n < 200 && !last_ch; n++) tick();
    chk("scf_reach_last", last_ch, 1);
    pulse(16'h9000, 1);
    chk("scf_overflow", overflow, 0);
    drain(400, 0);
    chk("scf_overflow_end", overflow, 0);

    $display("phase full_layer");
    do_reset();
    ifm_ready = 1'b1; xfer_cnt = 0;
    for (int p = 0; p < 256; p++) begin
      pulse(WIDTH'(p * 64), 1);
      if (p < 255) idle(64);
      if (p == 128) chk("layer_done_mid", done, 0);
    end
    for (int n = 0; n < 200 && sb.size() > 1; n++) tick();
    chk("layer_done_before_last", done, 0);
    tick();
    chk("layer_done_after_last", done, 1);
    chk("layer_xfers", xfer_cnt, 16384);
    chk("layer_valid", ifm_valid, 0);
    chk("layer_pix_sat", pix_idx, 255);
    chk("layer_drained", sb.size(), 0);
    sb.delete();
    pulse(16'hAAAA, 0);
    idle(5);
    chk("extra_overflow", overflow, 0);
    chk("extra_done", done, 1);
    chk("extra_valid", ifm_valid, 0);

    $display("phase reset_mid_stream");
    do_reset();
    ifm_ready = 1'b1;
    pulse(16'hB000, 1);
    for (int n = 0; n < 100 && !(ifm_valid && ch_idx == 6'd30); n++) tick();
    chk("mid_reach_word30", ifm_valid && (ch_idx == 6'd30), 1);
    do_reset();
    pulse(16'hC000, 1);
    drain(200, 0);
    chk("mid_restart_pix", pix_idx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
